// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset PC and fetch FSM encoding for the instruction fetch stage.
package instr_fetch_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam logic [ADDR_W-1:0] MEM_OFFSET = 8'hC8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StDrain = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} pairs; flush empties it at the clock edge.
module fetch_queue
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic              c,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [WORD_W-1:0] push_instr,
   input  logic [ADDR_W-1:0] push_pc,
   output logic [WORD_W-1:0] head_instr,
   output logic [ADDR_W-1:0] head_pc,
   output logic [CntW-1:0]   count,
   output logic              full,
   output logic              empty
);

   logic [WORD_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0] pc_q    [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            instr_q[wr_ptr_q] <= push_instr;
            pc_q[wr_ptr_q]    <= push_pc;
            wr_ptr_q          <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   assign head_instr = instr_q[rd_ptr_q];
   assign head_pc    = pc_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding memory request at a time, advances the PC once per
// accepted fetch, and discards wrong-path work on a taken branch.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic              c,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              esc_pc,
   input  logic              halt_in,
   output logic              halt_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              dec_ready
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic            push, pop, full, empty;
   logic [CntW-1:0] count, count_on_ack;

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .c         (c),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (esc_pc),
      .push_instr(mem_rdata),
      .push_pc   (pc_in),
      .head_instr(ir),
      .head_pc   (ir_pc),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign ir_valid = ~empty;
   assign pop      = ir_valid & dec_ready;
   assign mem_addr = pc_in;
   assign mem_req  = (state_q != StIdle);

   // Occupancy after an accepted ack, including a same-cycle pop.
   assign count_on_ack = count + CntW'(1) - CntW'(pop);

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      halt_pc = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!full && !halt_in && !esc_pc) state_d = StWait;
         end
         StWait: begin
            if (esc_pc) begin
               state_d = mem_ack ? StIdle : StDrain;
            end else if (mem_ack) begin
               push    = 1'b1;
               halt_pc = halt_in;
               state_d = (count_on_ack < CntW'(DEPTH) && !halt_in) ? StWait : StIdle;
            end
         end
         StDrain: begin
            if (mem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A taken branch always lets the PC load its target.
      if (esc_pc) halt_pc = 1'b0;
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

endmodule
